// File: rtl/identity_checker.sv
// identity_checker: drives every 3-bit input combination onto an external
// combinational DUT, holds each one for DWELL cycles, then compares the
// DUT's lhs/rhs outputs and accumulates a pass/fail report.
//
// Ports:
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   start          begin a sweep (ignored while a sweep is running)
//   lhs, rhs       DUT outputs under comparison
//   x, y, z        DUT inputs, {x,y,z} = current vector index
//   busy, done     sweep running / sweep finished with results valid
//   pass           every vector matched (only while done)
//   err_count      number of mismatching vectors
//   fail_valid     at least one mismatch recorded
//   first_fail     lowest mismatching vector index
//   mismatch_mask  bit k set iff vector k mismatched
module identity_checker #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned N_IN  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       lhs,
  input  logic       rhs,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] first_fail,
  output logic [7:0] mismatch_mask
);

  localparam int unsigned NV = 2 ** N_IN;
  localparam int unsigned CW = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned EW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [EW-1:0]   err_q, err_d;
  logic            fv_q, fv_d;
  logic [IW-1:0]   ff_q, ff_d;
  logic [NV-1:0]   mask_q, mask_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ff_q    <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state, sweep sequencing and result accumulation
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ff_d    = ff_q;
    mask_d  = mask_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;

    unique case (state_q)
      IDLE, DONE: begin
        // A start from either resting state begins a fresh sweep
        if (start) begin
          state_d = APPLY;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          ff_d    = '0;
          mask_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      APPLY: begin
        cnt_d = cnt_q + CW'(1);
        // Last cycle of the dwell window: lhs/rhs have settled for this vector
        if (cnt_q == CW'(DWELL - 1)) begin
          cnt_d = '0;
          if (lhs != rhs) begin
            mask_d[idx_q] = 1'b1;
            err_d         = err_q + EW'(1);
            if (!fv_q) begin
              ff_d = idx_q;
              fv_d = 1'b1;
            end
          end
          if (idx_q == IW'(NV - 1)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign x             = idx_q[2];
  assign y             = idx_q[1];
  assign z             = idx_q[0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign fail_valid    = fv_q;
  assign first_fail    = ff_q;
  assign mismatch_mask = mask_q;

endmodule

// File: tb/tb_identity_checker.sv
// Bench for identity_checker: two instances (DWELL=4 and DWELL=1) driving a
// modelled lab DUT whose rhs differs from lhs on a chosen set of vectors.
module tb_identity_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start [2];
  logic       lhs [2];
  logic       rhs [2];
  logic       x [2];
  logic       y [2];
  logic       z [2];
  logic       busy [2];
  logic       done [2];
  logic       pass [2];
  logic [3:0] ec [2];
  logic       fv [2];
  logic [2:0] ff [2];
  logic [7:0] mm [2];

  logic [7:0] fmask [2];   // vectors where the lab DUT's rhs is wrong
  logic       gl_en [2];   // flip rhs on every non-sampling cycle
  logic       gl_r  [2];

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  identity_checker #(.DWELL(4), .N_IN(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .lhs(lhs[0]), .rhs(rhs[0]),
    .x(x[0]), .y(y[0]), .z(z[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(ec[0]), .fail_valid(fv[0]), .first_fail(ff[0]), .mismatch_mask(mm[0])
  );

  identity_checker #(.DWELL(1), .N_IN(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .lhs(lhs[1]), .rhs(rhs[1]),
    .x(x[1]), .y(y[1]), .z(z[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(ec[1]), .fail_valid(fv[1]), .first_fail(ff[1]), .mismatch_mask(mm[1])
  );

  // Lab DUT: lhs = x&y | z, rhs = lhs with injected faults and optional glitches
  assign lhs[0] = (x[0] & y[0]) | z[0];
  assign rhs[0] = lhs[0] ^ fmask[0][{x[0], y[0], z[0]}] ^ gl_r[0];
  assign lhs[1] = (x[1] & y[1]) | z[1];
  assign rhs[1] = lhs[1] ^ fmask[1][{x[1], y[1], z[1]}] ^ gl_r[1];

  function automatic int dw(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic f_lhs(input int k);
    logic [2:0] v;
    v = 3'(k);
    return (v[2] & v[1]) | v[0];
  endfunction

  // Mismatch contribution of the n-th edge of a sweep (zero if not a sample edge)
  function automatic logic [7:0] samp(input int i, input int n);
    logic [7:0] r;
    logic       l, rr;
    int         k;
    r = '0;
    if (n % dw(i) == 0) begin
      k  = n / dw(i) - 1;
      l  = f_lhs(k);
      rr = l ^ fmask[i][k];
      if (l != rr) r[k] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [2:0] lowest(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int k = 7; k >= 0; k--) if (m[k]) r = 3'(k);
    return r;
  endfunction

  // Reference model: elapsed edges since start and the set of failed vectors
  int         m_n [2];
  logic       m_run [2];
  logic       m_done [2];
  logic [7:0] m_mask [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_n[i]    <= 0;
        m_run[i]  <= 1'b0;
        m_done[i] <= 1'b0;
        m_mask[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_run[i]) begin
          m_n[i]    <= m_n[i] + 1;
          m_mask[i] <= m_mask[i] | samp(i, m_n[i] + 1);
          if (m_n[i] + 1 == 8 * dw(i)) begin
            m_run[i]  <= 1'b0;
            m_done[i] <= 1'b1;
          end
        end else if (start[i]) begin
          m_run[i]  <= 1'b1;
          m_n[i]    <= 0;
          m_done[i] <= 1'b0;
          m_mask[i] <= '0;
        end
      end
    end
  end

  // Glitch rhs only during cycles whose following edge is not a sample edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      gl_r[i] <= gl_en[i] && m_run[i] && (((m_n[i] + 1) % dw(i)) != 0);
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, i, $time, act, exp);
    end
  endtask

  task automatic cmp_all();
    logic [2:0] ev;
    for (int i = 0; i < 2; i++) begin
      ev = m_run[i] ? 3'(m_n[i] / dw(i)) : (m_done[i] ? 3'd7 : 3'd0);
      chk("xyz", i, 32'({x[i], y[i], z[i]}), 32'(ev));
      chk("busy", i, 32'(busy[i]), 32'(m_run[i]));
      chk("done", i, 32'(done[i]), 32'(m_done[i]));
      chk("pass", i, 32'(pass[i]), 32'(m_done[i] && (m_mask[i] == '0)));
      chk("err_count", i, 32'(ec[i]), 32'($countones(m_mask[i])));
      chk("fail_valid", i, 32'(fv[i]), 32'(|m_mask[i]));
      chk("first_fail", i, 32'(ff[i]), 32'(lowest(m_mask[i])));
      chk("mask", i, 32'(mm[i]), 32'(m_mask[i]));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_all();
  endtask

  // Start one sweep, optionally with stray start pulses, and pin the report
  task automatic run_sweep(input int i, input logic [7:0] fm, input logic g,
                           input logic stray, input logic e_pass,
                           input logic [3:0] e_ec, input logic [2:0] e_ff,
                           input logic e_fv);
    int c;
    fmask[i] = fm;
    gl_en[i] = g;
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
    c = 1;
    while (!done[i] && c < 300) begin
      tick();
      c++;
      if (!done[i] && stray) start[i] = ($urandom_range(3) == 0);
    end
    start[i] = 1'b0;
    chk("done_latency", i, 32'(c), 32'(8 * dw(i) + 1));
    chk("lit_pass", i, 32'(pass[i]), 32'(e_pass));
    chk("lit_err_count", i, 32'(ec[i]), 32'(e_ec));
    chk("lit_first_fail", i, 32'(ff[i]), 32'(e_ff));
    chk("lit_fail_valid", i, 32'(fv[i]), 32'(e_fv));
    chk("lit_mask", i, 32'(mm[i]), 32'(fm));
    chk("lit_xyz_hold", i, 32'({x[i], y[i], z[i]}), 32'(3'b111));
    gl_en[i] = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] fm;
    int         i;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0;
      fmask[k] = '0;
      gl_en[k] = 1'b0;
    end
    tick();
    tick();
    chk("rst_busy", 0, 32'(busy[0]), 32'(0));
    chk("rst_xyz", 0, 32'({x[0], y[0], z[0]}), 32'(0));
    chk("rst_mask", 0, 32'(mm[0]), 32'(0));
    rst_n = 1'b1;
    tick();

    // Directed sweeps
    run_sweep(0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 3'd0, 1'b0);
    run_sweep(0, 8'h80, 1'b0, 1'b0, 1'b0, 4'd1, 3'd7, 1'b1);
    run_sweep(0, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd8, 3'd0, 1'b1);
    run_sweep(0, 8'h0A, 1'b0, 1'b0, 1'b0, 4'd2, 3'd1, 1'b1);

    // Asynchronous reset while vector 3 is applied
    fmask[0] = 8'h24;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int k = 0; k < 13; k++) tick();
    chk("pre_rst_xyz", 0, 32'({x[0], y[0], z[0]}), 32'(3));
    chk("pre_rst_mask", 0, 32'(mm[0]), 32'(8'h04));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_xyz", 0, 32'({x[0], y[0], z[0]}), 32'(0));
    chk("arst_busy", 0, 32'(busy[0]), 32'(0));
    chk("arst_mask", 0, 32'(mm[0]), 32'(0));
    chk("arst_err_count", 0, 32'(ec[0]), 32'(0));
    chk("arst_fail_valid", 0, 32'(fv[0]), 32'(0));
    tick();
    rst_n = 1'b1;
    tick();
    run_sweep(0, 8'h24, 1'b0, 1'b0, 1'b0, 4'd2, 3'd2, 1'b1);

    // start held high through a whole sweep, then restart from DONE
    fmask[0] = 8'h11;
    start[0] = 1'b1;
    for (int k = 0; k < 300 && !done[0]; k++) tick();
    chk("held_done", 0, 32'(done[0]), 32'(1));
    chk("held_err_count", 0, 32'(ec[0]), 32'(2));
    tick();
    chk("restart_done", 0, 32'(done[0]), 32'(0));
    chk("restart_busy", 0, 32'(busy[0]), 32'(1));
    chk("restart_xyz", 0, 32'({x[0], y[0], z[0]}), 32'(0));
    chk("restart_err_count", 0, 32'(ec[0]), 32'(0));
    chk("restart_pass", 0, 32'(pass[0]), 32'(0));
    start[0] = 1'b0;
    for (int k = 0; k < 300 && !done[0]; k++) tick();
    chk("held_mask", 0, 32'(mm[0]), 32'(8'h11));
    tick();

    // DWELL=1 instance and glitch tolerance on the DWELL=4 instance
    run_sweep(1, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 3'd0, 1'b0);
    run_sweep(1, 8'h40, 1'b0, 1'b0, 1'b0, 4'd1, 3'd6, 1'b1);
    run_sweep(0, 8'h00, 1'b1, 1'b0, 1'b1, 4'd0, 3'd0, 1'b0);

    // Randomized fault sets, glitches and stray start pulses
    for (int r = 0; r < 12; r++) begin
      i  = int'($urandom_range(1));
      fm = 8'($urandom);
      if (r % 4 == 0) fm = '0;
      run_sweep(i, fm, (i == 0) && ($urandom_range(1) == 1), 1'b1,
                fm == '0, 4'($countones(fm)), lowest(fm), |fm);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/identity_checker.md
Name: identity_checker

Overview:
- Hardware response-side counterpart to the exhaustive 3-input identity benches. It sequences every input combination onto a combinational DUT (x, y, z), holds each one for a settling window, samples the DUT's lhs/rhs outputs, and reports the result.
- Reported result: pass/fail, mismatch count, first failing vector and a per-vector mismatch mask.
- Used to self-check Boolean-identity labs on hardware, with no simulator-side testbench.

Parameters:
- DWELL, 4, clock cycles each vector is held before lhs/rhs are sampled; legal range 1..255.
- N_IN, 3, number of DUT inputs; fixed at 3 for this revision. Derived: NV = 2**N_IN = 8 vectors.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled on rising edge.
- lhs  input  1  DUT left-hand-side output.
- rhs  input  1  DUT right-hand-side output.
- x  output  1  DUT input, vector bit 2 (MSB).
- y  output  1  DUT input, vector bit 1.
- z  output  1  DUT input, vector bit 0 (LSB).
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; results valid.
- pass  output  1  all vectors matched; meaningful only while done=1.
- err_count  output  4  number of mismatching vectors, 0..8.
- fail_valid  output  1  at least one mismatch recorded.
- first_fail  output  3  lowest vector index that mismatched; 0 when fail_valid=0.
- mismatch_mask  output  8  bit k set iff vector k mismatched.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; x, y, z = 000; state IDLE; vector index = 0; dwell counter = 0.
- FSM states: IDLE, APPLY, DONE. {x, y, z} is always the registered vector index.
- IDLE:
  - start=1 at edge T: go to APPLY, index=0, counter=0, busy=1.
  - At the same edge, clear err_count, fail_valid, first_fail and mismatch_mask.
- APPLY:
  - counter increments every cycle.
  - On the edge where counter==DWELL-1, compare the lhs and rhs values present before that edge.
  - On mismatch: mask[index]=1 and err_count+1. If fail_valid=0, set first_fail=index and fail_valid=1.
  - Then counter=0. If index==7, go to DONE; otherwise index+1.
- Timing: vector k is driven from edge T+k*DWELL and sampled at edge T+(k+1)*DWELL. At edge T+8*DWELL: busy=0, done=1.
- Start during APPLY: ignored.
- DONE:
  - done=1; pass = (err_count==0).
  - x, y, z hold 111 (last vector).
  - All results hold.
  - start=1 at an edge re-enters APPLY exactly as from IDLE: done=0, pass=0, results cleared, index=0.
- pass is 0 in every state other than DONE.
- Reset mid-sweep: immediate (asynchronous) return to reset values; the partial sweep is discarded.
- err_count cannot overflow (max 8 fits in 4 bits); no saturation logic.
- DWELL=1 is legal: one vector per cycle; done at edge T+8.

Test Plan:
1. Identity holds (rhs tied to lhs, lhs = x&y|z), DWELL=4, start pulse at edge T -> x,y,z step 000..111 every 4 cycles; done=1 at T+32; pass=1, err_count=0, fail_valid=0, mask=8'h00.
2. Single-point fault rhs = lhs ^ (x&y&z) -> done at T+32; pass=0, err_count=1, first_fail=7, fail_valid=1, mask=8'h80.
3. Total fault rhs = ~lhs -> err_count=8, first_fail=0, mask=8'hFF, pass=0. Fault rhs = lhs ^ (~x&z) -> mask=8'h0A, err_count=2, first_fail=1.
4. rst_n low for one cycle while vector 3 is applied -> all outputs 0 asynchronously, before the next edge. A new start then completes a full 32-cycle sweep with correct results.
5. start held high throughout the sweep -> no restart while busy. At DONE the next edge restarts: done drops, results clear, x,y,z=000, busy=1.
6. DWELL=1 build, identity-holds stimulus -> vector changes every cycle; done at T+8, pass=1. A glitch on rhs only during non-sample cycles of a DWELL=4 build -> pass=1.
